// File: rtl/bch_encoder_if.sv
// Word-stream handshake bundle between a message source, bch_encoder and its codeword sink.
// The error-injection controls exist only when BCH_ERR_INJ_EN is defined.
interface bch_encoder_if;
    logic        set;
    logic [1:0]  code;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef BCH_ERR_INJ_EN
    logic [1:0]  inj_en;
    logic [9:0]  inj_pos0;
    logic [9:0]  inj_pos1;
`endif

    modport master (
        output set, code, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy, done
`ifdef BCH_ERR_INJ_EN
        , output inj_en, inj_pos0, inj_pos1
`endif
    );

    modport slave (
        input  set, code, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy, done
`ifdef BCH_ERR_INJ_EN
        , input inj_en, inj_pos0, inj_pos1
`endif
    );
endinterface

// File: rtl/bch_encoder.sv
// Systematic BCH encoder for (63,51), (255,239) and (1023,983) codes over a 64-bit word stream.
// Defining BCH_ERR_INJ_EN adds up to two deliberate coefficient flips per codeword.
module bch_encoder #(
    parameter int          BPC = 8,
    parameter logic [11:0] G1  = 12'h539,
    parameter logic [15:0] G2  = 16'h6F63,
    parameter logic [39:0] G3  = 40'h0
) (
    input logic          clk,
    input logic          rst,
    bch_encoder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PAR, OUT} state_t;

    state_t       state, state_next;
    logic [1:0]   code_q;
    logic [39:0]  lfsr, lfsr_next;
    logic [63:0]  buffer  [16];
    logic [63:0]  par_buf [16];
    logic [3:0]   widx, ridx;
    logic [6:0]   pos;
    logic [3:0]   last_idx;
    logic [6:0]   last_bits;
    logic [5:0]   top;
    logic [39:0]  gpoly, rmask;
    logic [6:0]   word_bits, rem, step_bits;
    logic [BPC-1:0] chunk;
    logic         word_end;
    logic         set_ok;
    logic         done_q;
`ifdef BCH_ERR_INJ_EN
    logic [1:0]   inj_en_q;
    logic [9:0]   inj_pos0_q, inj_pos1_q;
    logic [9:0]   n_len, s0, s1;
`endif

    assign set_ok = (state == IDLE) && bus.set && (bus.code != 2'd0);

    // Per-code geometry; the last word always carries k%64 message bits, r parity bits and one pad bit.
    always_comb begin
        last_idx  = 4'd15;
        last_bits = 7'd23;
        top       = 6'd39;
        gpoly     = G3;
        rmask     = {40{1'b1}};
        case (code_q)
            2'd1: begin
                last_idx  = 4'd0;
                last_bits = 7'd51;
                top       = 6'd11;
                gpoly     = {28'b0, G1};
                rmask     = 40'h00_0000_0FFF;
            end
            2'd2: begin
                last_idx  = 4'd3;
                last_bits = 7'd47;
                top       = 6'd15;
                gpoly     = {24'b0, G2};
                rmask     = 40'h00_0000_FFFF;
            end
            default: ;
        endcase
    end

    always_comb begin
        word_bits = (widx == last_idx) ? last_bits : 7'd64;
        rem       = word_bits - pos;
        step_bits = (rem > 7'(BPC)) ? 7'(BPC) : rem;
        chunk     = BPC'((buffer[widx] << pos) >> (64 - BPC));
        lfsr_next = lfsr;
        for (int i = 0; i < BPC; i++) begin
            if (7'(i) < step_bits)
                lfsr_next = ((lfsr_next << 1) & rmask)
                          ^ (((chunk[BPC-1-i] ^ lfsr_next[top]) != 1'b0) ? gpoly : 40'h0);
        end
    end

    assign word_end = (rem <= 7'(BPC));

    // Final word image: keep message bits, drop padding, place parity MSB-first just above the pad bit.
    always_comb begin
        for (int w = 0; w < 16; w++)
            par_buf[w] = buffer[w];
        par_buf[last_idx] = (buffer[last_idx] & ~({64{1'b1}} >> last_bits)) | {23'b0, lfsr, 1'b0};
`ifdef BCH_ERR_INJ_EN
        n_len = {last_idx, 6'd63};
        s0    = n_len - 10'd1 - inj_pos0_q;
        s1    = n_len - 10'd1 - inj_pos1_q;
        for (int w = 0; w < 16; w++) begin
            if (inj_en_q[0] && (inj_pos0_q < n_len) && (s0[9:6] == 4'(w)))
                par_buf[w] = par_buf[w] ^ (64'h8000_0000_0000_0000 >> s0[5:0]);
            if (inj_en_q[1] && (inj_pos1_q < n_len) && (s1[9:6] == 4'(w)))
                par_buf[w] = par_buf[w] ^ (64'h8000_0000_0000_0000 >> s1[5:0]);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (set_ok) state_next = LOAD;
            LOAD:  if (bus.in_valid) state_next = SHIFT;
            SHIFT: if (word_end) state_next = (widx == last_idx) ? PAR : LOAD;
            PAR:   state_next = OUT;
            OUT:   if (bus.out_ready && (ridx == last_idx)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= 2'd0;
            lfsr   <= '0;
            widx   <= '0;
            ridx   <= '0;
            pos    <= '0;
            done_q <= 1'b0;
            for (int w = 0; w < 16; w++)
                buffer[w] <= '0;
`ifdef BCH_ERR_INJ_EN
            inj_en_q   <= '0;
            inj_pos0_q <= '0;
            inj_pos1_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (set_ok) begin
                    code_q <= bus.code;
                    lfsr   <= '0;
                    widx   <= '0;
                    ridx   <= '0;
                    pos    <= '0;
                    for (int w = 0; w < 16; w++)
                        buffer[w] <= '0;
`ifdef BCH_ERR_INJ_EN
                    inj_en_q   <= bus.inj_en;
                    inj_pos0_q <= bus.inj_pos0;
                    inj_pos1_q <= bus.inj_pos1;
`endif
                end
                LOAD: if (bus.in_valid) buffer[widx] <= bus.in_data;
                SHIFT: begin
                    lfsr <= lfsr_next;
                    if (word_end) begin
                        pos <= '0;
                        if (widx != last_idx)
                            widx <= widx + 4'd1;
                    end else begin
                        pos <= pos + 7'(BPC);
                    end
                end
                PAR: for (int w = 0; w < 16; w++)
                    buffer[w] <= par_buf[w];
                OUT: if (bus.out_ready) begin
                    ridx   <= ridx + 4'd1;
                    done_q <= (ridx == last_idx);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = (state == OUT) ? buffer[ridx] : 64'h0;
    assign bus.out_last  = (state == OUT) && (ridx == last_idx);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bch_encoder.sv
// Bench for bch_encoder: a long-division codeword model feeds a scoreboard checked on every output cycle.
// Build with BCH_ERR_INJ_EN defined to also exercise error injection.
`timescale 1ns/1ps
module tb_bch_encoder;
    localparam int          BPC = 8;
    localparam logic [11:0] G1  = 12'h539;
    localparam logic [15:0] G2  = 16'h6F63;
    // Any polynomial exercises the code-3 datapath; an odd value keeps the constant term present.
    localparam logic [39:0] G3  = 40'h91_D3B6_4A7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bch_encoder_if bus();

    bch_encoder #(.BPC(BPC), .G1(G1), .G2(G2), .G3(G3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int xfers  = 0;
    logic [63:0] exp_q [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: no response within cycle budget", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int words_for(input int c);
        return (c == 1) ? 1 : (c == 2) ? 4 : 16;
    endfunction

    // Codeword from plain polynomial long division over the stream-ordered bit list.
    function automatic void model_encode(input int c, input logic [63:0] msg [16], input logic [1:0] ie,
                                         input int p0, input int p1, output logic [63:0] cw [16]);
        int k, n, r, s;
        logic [40:0] g;
        bit div [1024];
        case (c)
            1:       begin k = 51;  n = 63;   r = 12; g = {28'b0, 1'b1, G1}; end
            2:       begin k = 239; n = 255;  r = 16; g = {24'b0, 1'b1, G2}; end
            default: begin k = 983; n = 1023; r = 40; g = {1'b1, G3}; end
        endcase
        for (int i = 0; i < 1024; i++) div[i] = 1'b0;
        for (int i = 0; i < 16; i++) cw[i] = 64'h0;
        for (int i = 0; i < k; i++) div[i] = msg[i/64][63-(i%64)];
        for (int i = 0; i < k; i++)
            if (div[i])
                for (int j = 0; j <= r; j++) div[i+j] = div[i+j] ^ g[r-j];
        for (int i = 0; i < n; i++)
            cw[i/64][63-(i%64)] = (i < k) ? msg[i/64][63-(i%64)] : div[i];
        if (ie[0] && p0 < n) begin
            s = n - 1 - p0;
            cw[s/64][63-(s%64)] = ~cw[s/64][63-(s%64)];
        end
        if (ie[1] && p1 < n) begin
            s = n - 1 - p1;
            cw[s/64][63-(s%64)] = ~cw[s/64][63-(s%64)];
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            checkOutput("out_valid_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                checkOutput("out_data", bus.out_data, exp_q[0]);
                checkOutput("out_last", 64'(bus.out_last), 64'(exp_q.size() == 1));
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    xfers++;
                end
            end
        end
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"},      64'(bus.busy),      64'd0);
        checkOutput({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_out_data"},  bus.out_data,       64'd0);
        checkOutput({tag, "_out_last"},  64'(bus.out_last),  64'd0);
        checkOutput({tag, "_done"},      64'(bus.done),      64'd0);
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic [63:0] msg [16], input int nw);
        int guard;
        bus.code = c;
        bus.set  = 1'b1;
        step();
        bus.set = 1'b0;
        checkOutput("busy_after_set", 64'(bus.busy), 64'd1);
        for (int w = 0; w < nw; w++) begin
            guard = 0;
            bus.in_data  = msg[w];
            bus.in_valid = 1'b1;
            while (!bus.in_ready && guard < 100) begin
                step();
                guard++;
            end
            if (!bus.in_ready) timeoutFail("in_ready_timeout");
            step();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drainOutput(input int stall_after, input int stall_len, input bit set_in_out);
        int guard, seen;
        bit got_done, set_sent, xfer;
        guard = 0; seen = 0; got_done = 1'b0; set_sent = 1'b0;
        bus.out_ready = 1'b1;
        while (!got_done && guard < 600) begin
            xfer = bus.out_valid && bus.out_ready;
            if (set_in_out && !set_sent && bus.out_valid) begin
                bus.code = 2'd2;
                bus.set  = 1'b1;
                set_sent = 1'b1;
            end
            step();
            bus.set = 1'b0;
            guard++;
            if (bus.done) begin
                got_done = 1'b1;
            end else if (xfer) begin
                seen++;
                if (seen == stall_after) begin
                    bus.out_ready = 1'b0;
                    repeat (stall_len) step();
                    bus.out_ready = 1'b1;
                end
            end
        end
        if (!got_done) begin
            timeoutFail("done_timeout");
        end else begin
            checkOutput("busy_at_done", 64'(bus.busy), 64'd0);
            checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
            step();
            checkOutput("done_one_cycle", 64'(bus.done), 64'd0);
            checkOutput("stay_idle", 64'(bus.in_ready), 64'd0);
        end
    endtask

    task automatic runCode(input int c, input logic [63:0] msg [16], input int stall_after,
                           input int stall_len, input bit set_in_out,
                           input logic [1:0] ie, input int p0, input int p1);
        logic [63:0] cw [16];
        int x0;
        model_encode(c, msg, ie, p0, p1, cw);
        for (int w = 0; w < words_for(c); w++) exp_q.push_back(cw[w]);
`ifdef BCH_ERR_INJ_EN
        bus.inj_en   = ie;
        bus.inj_pos0 = 10'(p0);
        bus.inj_pos1 = 10'(p1);
`endif
        x0 = xfers;
        applyStimulus(2'(c), msg, words_for(c));
        drainOutput(stall_after, stall_len, set_in_out);
        checkOutput("word_count", 64'(xfers - x0), 64'(words_for(c)));
    endtask

    initial begin
        logic [63:0] msg [16];
        logic [63:0] cw  [16];
        int guard;

        bus.set = 1'b0; bus.code = 2'd0; bus.in_data = 64'h0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
`ifdef BCH_ERR_INJ_EN
        bus.inj_en = 2'b00; bus.inj_pos0 = 10'd0; bus.inj_pos1 = 10'd0;
`endif
        #2;
        checkIdle("reset");
        repeat (2) step();
        rst = 1'b0;
        step();

        $display("[TB] code 1, all-zero message");
        for (int w = 0; w < 16; w++) msg[w] = 64'h0;
        model_encode(1, msg, 2'b00, 0, 0, cw);
        checkOutput("pin_zero_word", cw[0], 64'h0);
        runCode(1, msg, 0, 0, 1'b0, 2'b00, 0, 0);

        $display("[TB] code 1, m(x)=1");
        msg[0] = 64'h2000;
        model_encode(1, msg, 2'b00, 0, 0, cw);
        checkOutput("pin_code1_unit", cw[0], 64'h0000_0000_0000_2A72);
        runCode(1, msg, 0, 0, 1'b0, 2'b00, 0, 0);

        $display("[TB] code 2, m(x)=1");
        for (int w = 0; w < 16; w++) msg[w] = 64'h0;
        msg[3] = 64'h2_0000;
        model_encode(2, msg, 2'b00, 0, 0, cw);
        checkOutput("pin_code2_word0", cw[0], 64'h0);
        checkOutput("pin_code2_word3", cw[3], 64'h0000_0000_0002_DEC6);
        runCode(2, msg, 0, 0, 1'b0, 2'b00, 0, 0);

        $display("[TB] code 2, random message with output stall");
        for (int w = 0; w < 3; w++) msg[w] = {$urandom, $urandom};
        msg[3] = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFE_0000;
        runCode(2, msg, 2, 5, 1'b0, 2'b00, 0, 0);

        $display("[TB] code 3, random message");
        for (int w = 0; w < 15; w++) msg[w] = {$urandom, $urandom};
        msg[15] = {$urandom, $urandom} & 64'hFFFF_FE00_0000_0000;
        runCode(3, msg, 7, 3, 1'b0, 2'b00, 0, 0);

        $display("[TB] reset during code-3 shift");
        bus.code = 2'd3;
        bus.set  = 1'b1;
        step();
        bus.set = 1'b0;
        for (int w = 0; w < 3; w++) begin
            guard = 0;
            bus.in_data  = {$urandom, $urandom};
            bus.in_valid = 1'b1;
            while (!bus.in_ready && guard < 100) begin
                step();
                guard++;
            end
            if (!bus.in_ready) timeoutFail("abort_in_ready_timeout");
            step();
            bus.in_valid = 1'b0;
        end
        checkOutput("shift_busy", 64'(bus.busy), 64'd1);
        checkOutput("shift_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkIdle("abort");
        step();
        rst = 1'b0;
        step();
        for (int w = 0; w < 16; w++) msg[w] = 64'h0;
        runCode(1, msg, 0, 0, 1'b0, 2'b00, 0, 0);

        $display("[TB] set during OUT, set with code 0 in IDLE");
        msg[0] = 64'h2000;
        runCode(1, msg, 0, 0, 1'b1, 2'b00, 0, 0);
        bus.code = 2'd0;
        bus.set  = 1'b1;
        step();
        bus.set = 1'b0;
        checkOutput("code0_busy", 64'(bus.busy), 64'd0);
        checkOutput("code0_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (3) step();
        checkOutput("code0_still_idle", 64'(bus.busy), 64'd0);
        checkOutput("code0_no_output", 64'(bus.out_valid), 64'd0);

`ifdef BCH_ERR_INJ_EN
        $display("[TB] error injection");
        msg[0] = 64'h2000;
        // c_0 sits at stream index 62, i.e. bit 1 of the single code-1 word.
        model_encode(1, msg, 2'b01, 0, 0, cw);
        checkOutput("pin_inj_pos0", cw[0], 64'h0000_0000_0000_2A70);
        runCode(1, msg, 0, 0, 1'b0, 2'b01, 0, 0);
        model_encode(1, msg, 2'b01, 63, 0, cw);
        checkOutput("pin_inj_out_of_range", cw[0], 64'h0000_0000_0000_2A72);
        runCode(1, msg, 0, 0, 1'b0, 2'b01, 63, 0);
        runCode(1, msg, 0, 0, 1'b0, 2'b11, 5, 5);
        runCode(1, msg, 0, 0, 1'b0, 2'b11, 62, 12);
        bus.inj_en = 2'b00;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
